// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encoding and default data width.
package alu_pkg;

    // Default operand/result width.
    localparam int ALU_WIDTH = 8;

    // Operation select encoding, matching the 4-bit ALU_Sel bus.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_MUL  = 4'b0010,
        ALU_DIV  = 4'b0011,
        ALU_SHL  = 4'b0100,
        ALU_SHR  = 4'b0101,
        ALU_ROL  = 4'b0110,
        ALU_ROR  = 4'b0111,
        ALU_AND  = 4'b1000,
        ALU_OR   = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_NOR  = 4'b1011,
        ALU_NAND = 4'b1100,
        ALU_XNOR = 4'b1101,
        ALU_GT   = 4'b1110,
        ALU_EQ   = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle of the ALU plus the clock/reset bundle used by the harness.
interface intf
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic             CarryOut;

    // Driver side: supplies operands, observes registered results.
    modport master (
        output A,
        output B,
        output ALU_Sel,
        input  ALU_Out,
        input  CarryOut
    );

    // ALU side: consumes operands, drives registered results.
    modport slave (
        input  A,
        input  B,
        input  ALU_Sel,
        output ALU_Out,
        output CarryOut
    );
endinterface

// Clock and synchronous active-low reset carried together for the harness.
interface clk_if ();
    logic clk;
    logic rst_n;
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: selects one of sixteen operations and
// always reports the carry out of A+B regardless of the selected operation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  alu_op_e          sel_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH:0] sum_s;

    // Widened sum: low bits feed the ADD result, top bit is the carry for every opcode.
    always_comb begin
        sum_s   = {1'b0, a_i} + {1'b0, b_i};
        carry_o = sum_s[WIDTH];
    end

    // Operation decode; arithmetic results keep only the low WIDTH bits.
    always_comb begin
        result_o = ZERO_W;
        case (sel_i)
            ALU_ADD:  result_o = sum_s[WIDTH-1:0];
            ALU_SUB:  result_o = a_i - b_i;
            ALU_MUL:  result_o = a_i * b_i;
            ALU_DIV: begin
                // Divide-by-zero yields zero rather than an undefined quotient.
                if (b_i == ZERO_W) begin
                    result_o = ZERO_W;
                end else begin
                    result_o = a_i / b_i;
                end
            end
            ALU_SHL:  result_o = {a_i[WIDTH-2:0], 1'b0};
            ALU_SHR:  result_o = {1'b0, a_i[WIDTH-1:1]};
            ALU_ROL:  result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
            ALU_ROR:  result_o = {a_i[0], a_i[WIDTH-1:1]};
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_NAND: result_o = ~(a_i & b_i);
            ALU_XNOR: result_o = ~(a_i ^ b_i);
            ALU_GT:   result_o = (a_i > b_i)  ? ONE_W : ZERO_W;
            ALU_EQ:   result_o = (a_i == b_i) ? ONE_W : ZERO_W;
            default:  result_o = ZERO_W;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: combinational core followed by a single output register
// stage, giving a fixed one-cycle latency with no input-to-output path.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    intf.slave   bus
);

    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;
    logic             carry_d;
    logic             carry_q;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (bus.A),
        .b_i      (bus.B),
        .sel_i    (alu_op_e'(bus.ALU_Sel)),
        .result_o (result_s),
        .carry_o  (carry_s)
    );

    // Next-state of the output register is simply the core result.
    always_comb begin
        alu_out_d = result_s;
        carry_d   = carry_s;
    end

    // Output register with synchronous active-low reset overriding any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_q <= {WIDTH{1'b0}};
            carry_q   <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            carry_q   <= carry_d;
        end
    end

    assign bus.ALU_Out  = alu_out_q;
    assign bus.CarryOut = carry_q;

endmodule

// File: tb/tb_alu.sv
// Directed and back-to-back checks of the registered ALU against hand values
// and an independent integer reference model.
module tb_alu;

    clk_if         cif ();
    intf #(.WIDTH(8)) bif ();

    alu #(.WIDTH(8)) dut (
        .clk   (cif.clk),
        .rst_n (cif.rst_n),
        .bus   (bif)
    );

    int n_total = 0;
    int n_bad   = 0;

    initial cif.clk = 1'b0;
    always #5 cif.clk = ~cif.clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        @(negedge cif.clk);
        bif.A       = a;
        bif.B       = b;
        bif.ALU_Sel = sel;
        @(posedge cif.clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic [7:0] exp_out, input logic exp_c);
        apply(a, b, sel);
        chk({tag, ".out"}, {8'h00, bif.ALU_Out}, {8'h00, exp_out});
        chk({tag, ".cy"},  {15'h0000, bif.CarryOut}, {15'h0000, exp_c});
    endtask

    // Integer-arithmetic reference: returns {carry, result}.
    function automatic logic [8:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] sel);
        int ia;
        int ib;
        int r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        c  = ((ia + ib) > 255);
        case (sel)
            4'd0:    r = (ia + ib) % 256;
            4'd1:    r = (ia - ib + 256) % 256;
            4'd2:    r = (ia * ib) % 256;
            4'd3:    r = (ib == 0) ? 0 : ia / ib;
            4'd4:    r = (ia * 2) % 256;
            4'd5:    r = ia / 2;
            4'd6:    r = ((ia * 2) % 256) + (ia / 128);
            4'd7:    r = (ia / 2) + ((ia % 2) * 128);
            4'd8:    r = int'(a & b);
            4'd9:    r = int'(a | b);
            4'd10:   r = int'(a ^ b);
            4'd11:   r = 255 - int'(a | b);
            4'd12:   r = 255 - int'(a & b);
            4'd13:   r = 255 - int'(a ^ b);
            4'd14:   r = (ia > ib) ? 1 : 0;
            4'd15:   r = (ia == ib) ? 1 : 0;
            default: r = 0;
        endcase
        return {c, r[7:0]};
    endfunction

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] exp9;
        logic [7:0] held_out;
        logic       held_c;

        // Reset held for two edges with an ADD that would otherwise carry.
        cif.rst_n   = 1'b0;
        bif.A       = 8'hFF;
        bif.B       = 8'h01;
        bif.ALU_Sel = 4'b0000;
        @(posedge cif.clk);
        @(posedge cif.clk);
        #1;
        chk("rst.out", {8'h00, bif.ALU_Out}, 16'h0000);
        chk("rst.cy",  {15'h0000, bif.CarryOut}, 16'h0000);

        // First edge after release registers FF+01 normally.
        @(negedge cif.clk);
        cif.rst_n = 1'b1;
        @(posedge cif.clk);
        #1;
        chk("rel.out", {8'h00, bif.ALU_Out}, 16'h0000);
        chk("rel.cy",  {15'h0000, bif.CarryOut}, 16'h0001);

        // Shift right, carry independent of the opcode.
        vec("shr96", 8'h96, 8'h80, 4'b0101, 8'h4B, 1'b1);
        vec("shr01", 8'h01, 8'h10, 4'b0101, 8'h00, 1'b0);
        vec("shr01b", 8'h01, 8'hFF, 4'b0101, 8'h00, 1'b1);
        vec("shl",   8'hC3, 8'h00, 4'b0100, 8'h86, 1'b0);

        // Arithmetic wrap, truncation, division.
        vec("add",  8'h7F, 8'h02, 4'b0000, 8'h81, 1'b0);
        vec("sub",  8'h05, 8'h07, 4'b0001, 8'hFE, 1'b0);
        vec("mul",  8'h10, 8'h10, 4'b0010, 8'h00, 1'b0);
        vec("div",  8'd100, 8'd7, 4'b0011, 8'd14, 1'b0);
        vec("div0", 8'd100, 8'd0, 4'b0011, 8'h00, 1'b0);

        // Rotates.
        vec("rol", 8'h81, 8'h00, 4'b0110, 8'h03, 1'b0);
        vec("ror", 8'h81, 8'h00, 4'b0111, 8'hC0, 1'b0);

        // Logic and compare.
        vec("and",  8'hF0, 8'h3C, 4'b1000, 8'h30, 1'b1);
        vec("nor",  8'hF0, 8'h3C, 4'b1011, 8'h03, 1'b1);
        vec("xnor", 8'hF0, 8'h3C, 4'b1101, 8'h33, 1'b1);
        vec("gt",   8'hF0, 8'h3C, 4'b1110, 8'h01, 1'b1);
        vec("gtno", 8'h3C, 8'hF0, 4'b1110, 8'h00, 1'b1);
        vec("eq",   8'h5A, 8'h5A, 4'b1111, 8'h01, 1'b0);
        vec("eqno", 8'h5A, 8'h5B, 4'b1111, 8'h00, 1'b0);

        // Outputs must hold while inputs change between edges.
        held_out    = bif.ALU_Out;
        held_c      = bif.CarryOut;
        bif.A       = 8'hFF;
        bif.B       = 8'hFF;
        bif.ALU_Sel = 4'b1001;
        #2;
        chk("hold.out", {8'h00, bif.ALU_Out}, {8'h00, held_out});
        chk("hold.cy",  {15'h0000, bif.CarryOut}, {15'h0000, held_c});
        chk("hold.val", {8'h00, bif.ALU_Out}, 16'h0000);

        // Back-to-back: new opcode every cycle, each result one cycle later.
        for (int i = 0; i < 16; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            exp9 = ref_model(ra, rb, 4'(i));
            apply(ra, rb, 4'(i));
            chk($sformatf("b2b%0d.out", i), {8'h00, bif.ALU_Out}, {8'h00, exp9[7:0]});
            chk($sformatf("b2b%0d.cy", i), {15'h0000, bif.CarryOut}, {15'h0000, exp9[8]});
        end

        // Reset mid-run overrides a carrying operation.
        @(negedge cif.clk);
        cif.rst_n   = 1'b0;
        bif.A       = 8'hFF;
        bif.B       = 8'hFF;
        bif.ALU_Sel = 4'b1100;
        @(posedge cif.clk);
        #1;
        chk("rst2.out", {8'h00, bif.ALU_Out}, 16'h0000);
        chk("rst2.cy",  {15'h0000, bif.CarryOut}, 16'h0000);
        @(negedge cif.clk);
        cif.rst_n = 1'b1;
        vec("post", 8'hAA, 8'h0F, 4'b1010, 8'hA5, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, 8, data width of A, B and ALU_Out.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 A  input  WIDTH  operand A, unsigned.
REQ-005 B  input  WIDTH  operand B, unsigned.
REQ-006 ALU_Sel  input  4  operation select.
REQ-007 ALU_Out  output  WIDTH  registered result.
REQ-008 CarryOut  output  1  registered carry of A+B.

Function
REQ-009 Each rising clk edge with rst_n=1 SHALL register the result of the current A, B, ALU_Sel; latency exactly 1 cycle, new result every cycle, no handshake.
REQ-010 ALU_Sel decode SHALL be: 0000 A+B; 0001 A-B; 0010 A*B; 0011 A/B; 0100 A<<1; 0101 A>>1; 0110 rotate A left 1; 0111 rotate A right 1; 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~(A|B); 1100 ~(A&B); 1101 ~(A^B); 1110 (A>B)?1:0; 1111 (A==B)?1:0.
REQ-011 Add, sub and mul SHALL truncate to the low WIDTH bits (sub wraps modulo 2^WIDTH; mul discards the upper half).
REQ-012 Division SHALL be unsigned integer quotient truncated toward zero; B=0 SHALL give ALU_Out=0.
REQ-013 Shifts SHALL be logical, zero-filled; rotates SHALL move the MSB to the LSB (left) or the LSB to the MSB (right).
REQ-014 Compare ops SHALL drive 1 or 0 zero-extended to WIDTH.
REQ-015 CarryOut SHALL be bit WIDTH of the (WIDTH+1)-bit sum A+B for every ALU_Sel value, not only 0000.
REQ-016 A change of inputs between edges SHALL NOT affect the outputs until the next edge; no combinational input-to-output path.

Reset
REQ-017 rst_n=0 at a rising edge SHALL force ALU_Out=0 and CarryOut=0, overriding any operation.
REQ-018 Reset SHALL have no asynchronous effect; outputs SHALL hold until the next edge.
REQ-019 The first edge with rst_n=1 SHALL register the current inputs normally.

Structure
REQ-020 A shared package SHALL hold the 4-bit opcode enum (ADD, SUB, MUL, DIV, SHL, SHR, ROL, ROR, AND, OR, XOR, NOR, NAND, XNOR, GT, EQ) and the default WIDTH constant.
REQ-021 The design SHALL split into one combinational sub-module alu_core (A, B, ALU_Sel -> result, carry) plus the output register stage in alu.
REQ-022 The verification harness SHALL use interface intf (A, B, ALU_Sel, ALU_Out, CarryOut) and interface clk_if (clk, rst_n); the tests drive intf and sample outputs one clk after applying inputs.

Verification
REQ-023 Reset: rst_n=0 for 2 edges with A=8'hFF, B=8'h01, Sel=0000 -> ALU_Out=0, CarryOut=0; release -> next edge ALU_Out=8'h00, CarryOut=1.
REQ-024 Shift right: Sel=0101, A=8'h96 -> ALU_Out=8'h4B; A=8'h01 -> 8'h00; CarryOut matches A+B carry for any B.
REQ-025 Arithmetic: Sel=0001, A=8'h05, B=8'h07 -> 8'hFE; Sel=0010, A=8'h10, B=8'h10 -> 8'h00; Sel=0011, A=8'd100, B=8'd7 -> 8'd14; B=0 -> 8'h00.
REQ-026 Rotates: Sel=0110, A=8'h81 -> 8'h03; Sel=0111, A=8'h81 -> 8'hC0.
REQ-027 Logic and compare: A=8'hF0, B=8'h3C -> Sel 1000 8'h30, 1011 8'h03, 1101 8'h33, 1110 8'h01; A=B=8'h5A with Sel 1111 -> 8'h01.
REQ-028 Back-to-back: change Sel every cycle through all 16 codes with random A, B -> each result appears exactly one cycle later and matches a reference model.
